// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared types, constants and helpers for the instruction cache
//
// Purpose: common address/word/line types, boolean and zero constants,
// cache FSM state encoding and the line word-select helper.
// Ports: none (package).

package icache_pkg;

  localparam int LINE_W = 128;
  localparam int WORD_W = 32;
  localparam int OFF_W  = 4;

  typedef logic [31:0]       addr_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [LINE_W-1:0] line_t;

  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;
  localparam addr_t ZERO_ADDR = 32'h0000_0000;
  localparam word_t ZERO_WORD = 32'h0000_0000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MISS = 1'b1
  } state_t;

  // Word k of a line lives at bits 32k+31:32k.
  function automatic word_t line_word(line_t line, logic [1:0] sel);
    word_t w;
    case (sel)
      2'd0:    w = line[31:0];
      2'd1:    w = line[63:32];
      2'd2:    w = line[95:64];
      default: w = line[127:96];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/icache_array.sv
// rtl/icache_array.sv - valid/tag/data storage for the direct-mapped instruction cache
//
// Purpose: register-based line storage with one combinational read port and
// one synchronous write port. Only the valid bits are reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid bits)
//   rd_idx          read index
//   rd_valid        valid bit of the indexed line
//   rd_tag          tag of the indexed line
//   rd_line         data of the indexed line
//   wr_en           write strobe: store tag/line and set valid
//   wr_idx          write index
//   wr_tag          tag to store
//   wr_line         line data to store

module icache_array
  import icache_pkg::*;
#(
  parameter int LINE_NUM = 64,
  parameter int IDX_W    = 6,
  parameter int TAG_W    = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output line_t            rd_line,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  line_t            wr_line
);

  logic [LINE_NUM-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  line_t               data_q [LINE_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= TRUE;
    end
  end

  // Tag and data need no reset: a line is never read as a hit while its valid bit is clear.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_line;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped blocking instruction cache between IF and memctrl
//
// Purpose: serves one instruction per cycle on a hit; on a miss fetches one
// 16-byte line from memctrl and fills it, then returns to lookup.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rdy               global ready; low freezes lookup/miss launch
//   if_req_valid      IF presents if_req_pc this cycle
//   if_req_pc         fetch PC (bits 1:0 ignored)
//   if_flush          discard this cycle's request
//   if_hit            combinational: if_inst is valid for if_req_pc
//   if_inst           instruction word (zero when no hit)
//   icache_fc_valid   registered line fetch request to memctrl
//   icache_fc_addr    registered line-aligned fetch address
//   icache_fc_done    one-cycle pulse: line returned
//   icache_fc_line    returned line data

module icache
  import icache_pkg::*;
#(
  parameter int LINE_NUM = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_pc,
  input  logic        if_flush,
  output logic        if_hit,
  output logic [31:0] if_inst,
  output logic        icache_fc_valid,
  output logic [31:0] icache_fc_addr,
  input  logic        icache_fc_done,
  input  logic [127:0] icache_fc_line
);

  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 32 - IDX_W - OFF_W;

  state_t state;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       req_sel;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  line_t            rd_line;
  logic             lookup_hit;
  logic             fill_en;
  logic [1:0]       unused_pc_bits;

  assign req_idx        = if_req_pc[IDX_W+3:4];
  assign req_tag        = if_req_pc[31:IDX_W+4];
  assign req_sel        = if_req_pc[3:2];
  assign unused_pc_bits = if_req_pc[1:0];

  // The fill address register doubles as the latched miss tag/index.
  assign fill_en = (state == ST_MISS) && icache_fc_done;

  icache_array #(
    .LINE_NUM (LINE_NUM),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill_en),
    .wr_idx   (icache_fc_addr[IDX_W+3:4]),
    .wr_tag   (icache_fc_addr[31:IDX_W+4]),
    .wr_line  (icache_fc_line)
  );

  // Hits only in IDLE, so the cycle a fill lands never reports a hit.
  assign lookup_hit = (state == ST_IDLE) && if_req_valid && rd_valid && (rd_tag == req_tag);
  assign if_hit     = lookup_hit && !if_flush;
  assign if_inst    = if_hit ? line_word(rd_line, req_sel) : ZERO_WORD;

  // A done pulse completes the fill even with rdy low: the pulse cannot be replayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      icache_fc_valid <= FALSE;
      icache_fc_addr  <= ZERO_ADDR;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rdy && if_req_valid && !lookup_hit && !if_flush) begin
            state           <= ST_MISS;
            icache_fc_valid <= TRUE;
            icache_fc_addr  <= {if_req_pc[31:4], 4'b0000};
          end
        end
        ST_MISS: begin
          if (icache_fc_done) begin
            state           <= ST_IDLE;
            icache_fc_valid <= FALSE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scenario bench for the direct-mapped instruction cache

module tb_icache;
  import icache_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_req_valid;
  logic [31:0] if_req_pc;
  logic        if_flush;
  logic        if_hit;
  logic [31:0] if_inst;
  logic        icache_fc_valid;
  logic [31:0] icache_fc_addr;
  logic        icache_fc_done;
  logic [127:0] icache_fc_line;

  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  icache dut (
    .clk             (clk),
    .rst             (rst),
    .rdy             (rdy),
    .if_req_valid    (if_req_valid),
    .if_req_pc       (if_req_pc),
    .if_flush        (if_flush),
    .if_hit          (if_hit),
    .if_inst         (if_inst),
    .icache_fc_valid (icache_fc_valid),
    .icache_fc_addr  (icache_fc_addr),
    .icache_fc_done  (icache_fc_done),
    .icache_fc_line  (icache_fc_line)
  );

  always #5 clk = ~clk;

  function automatic line_t mk_line(word_t base);
    return {base + 32'd3, base + 32'd2, base + 32'd1, base};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fc(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (icache_fc_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_done(line_t l);
    icache_fc_line = l;
    icache_fc_done = 1'b1;
    @(posedge clk);
    #1;
    icache_fc_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; if_req_valid = 1'b0; if_req_pc = '0;
    if_flush = 1'b0; icache_fc_done = 1'b0; icache_fc_line = '0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (icache_fc_valid !== 1'b0 || icache_fc_addr !== 32'h0 || if_hit !== 1'b0 || if_inst !== 32'h0) begin
      errors++;
      $display("FAIL reset: fc_valid=%b fc_addr=%h hit=%b inst=%h expected 0/0/0/0",
               icache_fc_valid, icache_fc_addr, if_hit, if_inst);
    end
  endtask

  task automatic test_basic_fill();
    word_t e;
    bit    seen;
    tick();
    if_req_valid = 1'b1; if_req_pc = 32'h0;
    @(negedge clk);
    checks++;
    if (if_hit !== 1'b0) begin errors++; $display("FAIL t1_cold_hit: hit=%b expected 0", if_hit); end
    tick();
    @(negedge clk);
    checks++;
    if (icache_fc_valid !== 1'b1 || icache_fc_addr !== 32'h0) begin
      errors++;
      $display("FAIL t1_launch: fc_valid=%b fc_addr=%h expected 1/00000000", icache_fc_valid, icache_fc_addr);
    end
    pulse_done(128'h44444444_33333333_22222222_11111111);
    exp_q.push_back(32'h11111111);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (if_hit !== 1'b1 || if_inst !== e) begin
      errors++; $display("FAIL t1_hit_w0: hit=%b inst=%h expected 1/%h", if_hit, if_inst, e);
    end
    if_req_pc = 32'hC;
    exp_q.push_back(32'h44444444);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (if_hit !== 1'b1 || if_inst !== e) begin
      errors++; $display("FAIL t1_hit_w3: hit=%b inst=%h expected 1/%h", if_hit, if_inst, e);
    end
    seen = 1'b0;
    tick();
  endtask

  task automatic test_conflict();
    word_t e;
    bit    seen;
    addr_t pcs [3] = '{32'h10, 32'h410, 32'h10};
    for (int i = 0; i < 3; i++) begin
      if_req_pc = pcs[i] + 32'h4;
      @(negedge clk);
      checks++;
      if (if_hit !== 1'b0) begin errors++; $display("FAIL t2_miss%0d: hit=%b expected 0", i, if_hit); end
      wait_fc(seen);
      checks++;
      if (!seen || icache_fc_addr !== pcs[i]) begin
        errors++; $display("FAIL t2_fc%0d: seen=%b fc_addr=%h expected 1/%h", i, seen, icache_fc_addr, pcs[i]);
      end
      pulse_done(mk_line(32'hB000_0000 + pcs[i] * 32'd16));
      exp_q.push_back(32'hB000_0000 + pcs[i] * 32'd16 + 32'd1);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (if_hit !== 1'b1 || if_inst !== e) begin
        errors++; $display("FAIL t2_hit%0d: hit=%b inst=%h expected 1/%h", i, if_hit, if_inst, e);
      end
      tick();
    end
  endtask

  task automatic test_flush();
    word_t e;
    bit    seen;
    if_req_pc = 32'h30;
    wait_fc(seen);
    checks++;
    if (!seen) begin errors++; $display("FAIL t3_launch: fc_valid never rose expected 1"); end
    if_flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (icache_fc_valid !== 1'b1 || icache_fc_addr !== 32'h30 || if_hit !== 1'b0) begin
        errors++;
        $display("FAIL t3_hold%0d: fc_valid=%b fc_addr=%h hit=%b expected 1/00000030/0",
                 i, icache_fc_valid, icache_fc_addr, if_hit);
      end
    end
    pulse_done(mk_line(32'hC000_0000));
    if_flush = 1'b0;
    exp_q.push_back(32'hC000_0000);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (if_hit !== 1'b1 || if_inst !== e || icache_fc_valid !== 1'b0) begin
      errors++;
      $display("FAIL t3_refill_hit: hit=%b inst=%h fc_valid=%b expected 1/%h/0", if_hit, if_inst, icache_fc_valid, e);
    end
    if_flush = 1'b1;
    #1;
    checks++;
    if (if_hit !== 1'b0) begin errors++; $display("FAIL t3_idle_flush: hit=%b expected 0", if_hit); end
    tick();
    @(negedge clk);
    checks++;
    if (icache_fc_valid !== 1'b0) begin
      errors++; $display("FAIL t3_flush_nolaunch: fc_valid=%b expected 0", icache_fc_valid);
    end
    if_flush = 1'b0;
    tick();
  endtask

  task automatic test_done_with_req();
    word_t e;
    bit    seen;
    if_req_pc = 32'h40;
    wait_fc(seen);
    icache_fc_line = mk_line(32'hD000_0000);
    icache_fc_done = 1'b1;
    if_req_pc = 32'h20;
    #1;
    checks++;
    if (!seen || if_hit !== 1'b0) begin
      errors++; $display("FAIL t4_done_cycle: seen=%b hit=%b expected 1/0", seen, if_hit);
    end
    tick();
    icache_fc_done = 1'b0;
    @(negedge clk);
    checks++;
    if (icache_fc_valid !== 1'b0 || if_hit !== 1'b0) begin
      errors++; $display("FAIL t4_after_done: fc_valid=%b hit=%b expected 0/0", icache_fc_valid, if_hit);
    end
    tick();
    @(negedge clk);
    checks++;
    if (icache_fc_valid !== 1'b1 || icache_fc_addr !== 32'h20) begin
      errors++; $display("FAIL t4_relaunch: fc_valid=%b fc_addr=%h expected 1/00000020", icache_fc_valid, icache_fc_addr);
    end
    pulse_done(mk_line(32'hE000_0000));
    if_req_pc = 32'h48;
    exp_q.push_back(32'hD000_0002);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (if_hit !== 1'b1 || if_inst !== e) begin
      errors++; $display("FAIL t4_fill_kept: hit=%b inst=%h expected 1/%h", if_hit, if_inst, e);
    end
    tick();
  endtask

  task automatic test_rdy();
    word_t e;
    bit    seen;
    rdy = 1'b0;
    if_req_pc = 32'h50;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      checks++;
      if (icache_fc_valid !== 1'b0 || if_hit !== 1'b0) begin
        errors++; $display("FAIL t5_frozen%0d: fc_valid=%b hit=%b expected 0/0", i, icache_fc_valid, if_hit);
      end
    end
    rdy = 1'b1;
    wait_fc(seen);
    rdy = 1'b0;
    tick();
    pulse_done(mk_line(32'hF000_0000));
    if_req_pc = 32'h58;
    exp_q.push_back(32'hF000_0002);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (!seen || icache_fc_valid !== 1'b0 || if_hit !== 1'b1 || if_inst !== e) begin
      errors++;
      $display("FAIL t5_done_rdy0: seen=%b fc_valid=%b hit=%b inst=%h expected 1/0/1/%h",
               seen, icache_fc_valid, if_hit, if_inst, e);
    end
    rdy = 1'b1;
    tick();
  endtask

  task automatic test_reset_in_miss();
    bit    seen;
    addr_t pcs [8] = '{32'h0, 32'h10, 32'h410, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60};
    if_req_pc = 32'h60;
    wait_fc(seen);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (!seen || icache_fc_valid !== 1'b0) begin
      errors++; $display("FAIL t6_rst_fc: seen=%b fc_valid=%b expected 1/0", seen, icache_fc_valid);
    end
    pulse_done(mk_line(32'h6000_0000));
    rdy = 1'b0;
    if_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if_req_pc = pcs[i];
      @(negedge clk);
      checks++;
      if (if_hit !== 1'b0 || icache_fc_valid !== 1'b0) begin
        errors++; $display("FAIL t6_invalid_%h: hit=%b fc_valid=%b expected 0/0", pcs[i], if_hit, icache_fc_valid);
      end
      tick();
    end
    rdy = 1'b1;
    if_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_conflict();
    test_flush();
    test_done_with_req();
    test_rdy();
    test_reset_in_miss();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
